// File: rtl/transition_pkg.sv
// Shared widths and event-entry layout for the transition logger.
package transition_pkg;

  localparam int TS_W_DEF     = 64;
  localparam int IN_W_DEF     = 8;
  localparam int DEPTH_L2_DEF = 5;
  localparam int DROP_W       = 16;

  // Entry packing, MSB first: {timeValid, changed, state, timestamp}
  function automatic int entry_w(input int ts_w, input int in_w);
    return 1 + 2 * in_w + ts_w;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO; head is combinational from storage, storage unreset.
module sync_fwft_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH_L2 = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                pop,
  output logic [WIDTH-1:0]    rdata,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_L2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_L2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_L2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_L2:0]   count_q, count_d;
  logic                wr, rd;

  assign full  = (count_q == DEPTH_L2'(0) + (DEPTH_L2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is legal then
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);

  always_comb begin
    wptr_d  = wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/transition_logger.sv
// Timestamps every change of the mitigation bits and queues it for a consumer.
module transition_logger
  import transition_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = TS_W_DEF,
  parameter int INPUT_WIDTH     = IN_W_DEF,
  parameter int FIFO_DEPTH_L2   = DEPTH_L2_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic                       secondsMarkerToggle,
  input  logic [INPUT_WIDTH-1:0]     mitigationIn,
  input  logic                       clearOverflow,
  input  logic                       eventReady,
  output logic                       eventValid,
  output logic [TIMESTAMP_WIDTH-1:0] eventTimestamp,
  output logic [INPUT_WIDTH-1:0]     eventState,
  output logic [INPUT_WIDTH-1:0]     eventChanged,
  output logic                       eventTimeValid,
  output logic [FIFO_DEPTH_L2:0]     fifoCount,
  output logic                       overflow,
  output logic [DROP_W-1:0]          droppedCount
);

  localparam int EW = entry_w(TIMESTAMP_WIDTH, INPUT_WIDTH);

  logic [INPUT_WIDTH-1:0] prev_q;
  logic                   armed_q, locked_q, locked_d, smt_q;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   trans, pop, full, empty, drop;
  logic [EW-1:0]          wentry, rentry;

  assign trans  = armed_q & (mitigationIn != prev_q);
  assign pop    = eventValid & eventReady;
  assign drop   = trans & full & ~pop;
  assign wentry = {locked_q, mitigationIn ^ prev_q, mitigationIn, timestamp};

  always_comb begin
    locked_d = locked_q | (secondsMarkerToggle != smt_q);
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    // A drop wins over a coincident clear so the lost event stays visible
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == '1) ? drop_q : drop_q + 1'b1;
    end else if (clearOverflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= '0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      smt_q    <= secondsMarkerToggle;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      prev_q   <= mitigationIn;
      armed_q  <= 1'b1;
      locked_q <= locked_d;
      smt_q    <= secondsMarkerToggle;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  sync_fwft_fifo #(.WIDTH(EW), .DEPTH_L2(FIFO_DEPTH_L2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (trans),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (fifoCount)
  );

  assign eventValid     = ~empty;
  assign eventTimestamp = rentry[TIMESTAMP_WIDTH-1:0];
  assign eventState     = rentry[TIMESTAMP_WIDTH +: INPUT_WIDTH];
  assign eventChanged   = rentry[TIMESTAMP_WIDTH+INPUT_WIDTH +: INPUT_WIDTH];
  assign eventTimeValid = rentry[EW-1];
  assign overflow       = ovf_q;
  assign droppedCount   = drop_q;

endmodule

// File: doc/transition_logger.md
TRANSITION_LOGGER -- requirements
Module: transition_logger

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64: width of the Aurora-domain timestamp, {seconds, ticks}.
REQ-002 SHALL have parameter INPUT_WIDTH, default 8: number of monitored mitigation bits.
REQ-003 SHALL have parameter FIFO_DEPTH_L2, default 5: log2 of event FIFO depth (32 entries).
REQ-004 SHALL have ports (name, direction, width, meaning) as follows.
- clk  in  1: Aurora clock, sole clock.
- rst_n  in  1: synchronous, active-low reset.
- timestamp  in  TIMESTAMP_WIDTH: current time from the upstream timestamp generator.
- secondsMarkerToggle  in  1: toggles once per PPS from the upstream timestamp generator.
- mitigationIn  in  INPUT_WIDTH: mitigation state bits, already synchronous to clk.
- clearOverflow  in  1: single-cycle pulse that clears the overflow status.
- eventReady  in  1: consumer accepts the head entry.
- eventValid  out  1: head entry present.
- eventTimestamp  out  TIMESTAMP_WIDTH: time of the transition.
- eventState  out  INPUT_WIDTH: new mitigation state.
- eventChanged  out  INPUT_WIDTH: bits that changed (XOR of old and new state).
- eventTimeValid  out  1: time was locked to PPS when captured.
- fifoCount  out  FIFO_DEPTH_L2+1: entries held.
- overflow  out  1: sticky, set when an event was dropped.
- droppedCount  out  16: dropped events, saturating.

Function
REQ-005 SHALL register mitigationIn as prevState every cycle; a transition occurs in cycle N when mitigationIn differs from prevState in cycle N.
REQ-006 SHALL capture the event with the timestamp value present in cycle N (zero skew), plus eventState = mitigationIn, eventChanged = mitigationIn XOR prevState, and eventTimeValid = timeLocked, all in the same cycle.
REQ-007 SHALL clear timeLocked at reset and set it on the first change of secondsMarkerToggle; it then stays set until the next reset.
REQ-008 SHALL write a captured event into the FIFO at the cycle N+1 clock edge, so eventValid rises in cycle N+1 when the FIFO was empty.
REQ-009 SHALL use a first-word-fall-through FIFO: head fields are valid whenever eventValid=1, and the head is popped at a clock edge where eventValid and eventReady are both 1.
REQ-010 SHALL hold the head fields stable while eventValid=1 and eventReady=0.
REQ-011 SHALL, on a transition while the FIFO is full with no pop in the same cycle, drop the event, set overflow, and increment droppedCount, saturating at 0xFFFF.
REQ-012 SHALL, on a transition while the FIFO is full with a pop in the same cycle, accept the event; fifoCount stays at its maximum and no drop is counted.
REQ-013 SHALL, on a simultaneous push and pop at any fill level, leave fifoCount unchanged.
REQ-014 SHALL, when clearOverflow coincides with a drop, leave overflow set and increment droppedCount; clearOverflow alone clears both overflow and droppedCount.
REQ-015 SHALL let read and write pointers wrap modulo 2^FIFO_DEPTH_L2; fifoCount SHALL report 0 to 2^FIFO_DEPTH_L2 inclusive.
REQ-016 SHALL suppress the first compare after reset release (armed flag): prevState loads from mitigationIn with no event generated.
REQ-017 SHALL treat transitions on consecutive cycles as separate events.

Reset
REQ-018 SHALL, while rst_n=0 at a clock edge, set: eventValid=0, fifoCount=0, overflow=0, droppedCount=0, timeLocked=0, armed=0, pointers=0.
REQ-019 SHALL, on reset mid-operation, discard all buffered events with no partial output; eventValid=0 from the first edge with rst_n=0.
REQ-020 SHALL leave FIFO storage RAM unreset.

Structure
REQ-021 SHALL place TIMESTAMP_WIDTH defaults, droppedCount width (16), and the entry-packing layout {timeValid, changed, state, timestamp} in a shared package, transition_pkg.
REQ-022 SHALL implement storage as one sub-module, sync_fwft_fifo (parameters WIDTH, DEPTH_L2), with push, pop, full, empty, and count.

Verification
REQ-023 SHALL cover: reset release with mitigationIn=0x3C held -> no event; eventValid stays 0.
REQ-024 SHALL cover: timestamp=0x0000_0005_0000_1000 in cycle N with mitigationIn 0x00->0x01 -> next cycle eventValid=1, eventTimestamp=0x0000000500001000, eventState=0x01, eventChanged=0x01, eventTimeValid=0.
REQ-025 SHALL cover: one secondsMarkerToggle change, then 0x01->0x81 -> eventTimeValid=1, eventChanged=0x80.
REQ-026 SHALL cover: eventReady=0 and 33 transitions -> fifoCount=32, overflow=1, droppedCount=1; a 34th transition in the same cycle as a pop -> accepted, droppedCount=1.
REQ-027 SHALL cover: droppedCount preloaded to 0xFFFF via drops, one more drop -> stays 0xFFFF; clearOverflow pulse -> overflow=0, droppedCount=0.
REQ-028 SHALL cover: rst_n=0 for one cycle with 5 entries buffered -> eventValid=0, fifoCount=0 the next cycle, and the armed-suppression of REQ-016 repeats.
